imem_fetch_ctrl: RTL and testbench

//  Sequences every access to the single-port instruction memory. Serves CPU

---
 rtl/imem_fetch_ctrl.sv | 149 ++++++++++++++
 tb/tb_imem_fetch_ctrl.sv | 292 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/imem_fetch_ctrl.sv
// imem_fetch_ctrl: arbitrates CPU instruction fetches and program-loader
// writes onto a single-port instruction memory with a fixed read latency.
// Fetches are exposed through a req/valid handshake plus a stall signal;
// loader writes complete in one cycle and are acknowledged with ld_ack.
// Optional feature: define IMEM_LINEBUF_EN to add a one-entry last-fetch
// buffer that answers repeated fetches of the same word without a memory read.
`timescale 1ns/1ps
module imem_fetch_ctrl #(
    parameter int ADDR_W  = 6,
    parameter int MEM_LAT = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              if_req,
    input  logic [31:0]       if_addr,
    output logic [31:0]       if_instr,
    output logic              if_valid,
    output logic              stall,
    input  logic              ld_req,
    input  logic [31:0]       ld_addr,
    input  logic [31:0]       ld_wdata,
    output logic              ld_ack,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_rd,
    output logic              mem_we,
    output logic [31:0]       mem_wdata,
    input  logic [31:0]       mem_rdata
);

    localparam int CNT_W = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_FETCH = 2'd1,
        S_WRITE = 2'd2,
        S_RESP  = 2'd3
    } state_t;

    state_t            r_state;
    logic [CNT_W-1:0]  r_cnt;
    logic              r_prio;

    logic [ADDR_W-1:0] w_if_idx;
    logic [ADDR_W-1:0] w_ld_idx;
    logic              w_grant_ld;
    logic              w_grant_if;
    logic              w_hit;
    logic              w_fetch_done;
    logic              w_unused;

    // Word index: byte-offset bits and bits above the memory depth are dropped
    assign w_if_idx = if_addr[ADDR_W+1:2];
    assign w_ld_idx = ld_addr[ADDR_W+1:2];
    assign w_unused = ^{if_addr[31:ADDR_W+2], if_addr[1:0],
                        ld_addr[31:ADDR_W+2], ld_addr[1:0]};

    // Loader wins a tie unless the previous grant was a write, which keeps
    // the two ports strictly alternating when both keep requesting
    assign w_grant_ld = ld_req & (~if_req | ~r_prio);
    assign w_grant_if = if_req & ~w_grant_ld;

    assign w_fetch_done = (r_state == S_FETCH) && (r_cnt == '0);

    // The CPU is stalled whenever it asks for an instruction that is not yet here
    assign stall = if_req & ~if_valid;

`ifdef IMEM_LINEBUF_EN
    logic              r_buf_vld;
    logic [ADDR_W-1:0] r_buf_tag;
    logic [31:0]       r_buf_data;

    assign w_hit = r_buf_vld && (r_buf_tag == w_if_idx);

    // Last-fetch buffer: refilled by every memory read, invalidated by a write to its word
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_buf_vld <= 1'b0;
        end else if (w_fetch_done) begin
            r_buf_vld  <= 1'b1;
            r_buf_tag  <= mem_addr;
            r_buf_data <= mem_rdata;
        end else if ((r_state == S_IDLE) && w_grant_ld && (w_ld_idx == r_buf_tag)) begin
            r_buf_vld <= 1'b0;
        end
    end
`else
    assign w_hit = 1'b0;
`endif

    // Access sequencer: grants in IDLE, times the memory read, pulses valid/ack
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state   <= S_IDLE;
            r_cnt     <= '0;
            r_prio    <= 1'b0;
            if_instr  <= '0;
            if_valid  <= 1'b0;
            ld_ack    <= 1'b0;
            mem_addr  <= '0;
            mem_rd    <= 1'b0;
            mem_we    <= 1'b0;
            mem_wdata <= '0;
        end else begin
            if_valid <= 1'b0;
            ld_ack   <= 1'b0;
            mem_we   <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (w_grant_ld) begin
                        r_state   <= S_WRITE;
                        r_prio    <= 1'b1;
                        mem_addr  <= w_ld_idx;
                        mem_wdata <= ld_wdata;
                        mem_we    <= 1'b1;
                        ld_ack    <= 1'b1;
                    end else if (w_grant_if) begin
                        r_prio <= 1'b0;
                        if (w_hit) begin
`ifdef IMEM_LINEBUF_EN
                            if_instr <= r_buf_data;
`endif
                            if_valid <= 1'b1;
                            r_state  <= S_RESP;
                        end else begin
                            mem_addr <= w_if_idx;
                            mem_rd   <= 1'b1;
                            r_cnt    <= CNT_W'(MEM_LAT - 1);
                            r_state  <= S_FETCH;
                        end
                    end
                end
                S_FETCH: begin
                    if (r_cnt == '0) begin
                        mem_rd   <= 1'b0;
                        if_instr <= mem_rdata;
                        if_valid <= 1'b1;
                        r_state  <= S_RESP;
                    end else begin
                        r_cnt <= r_cnt - 1'b1;
                    end
                end
                S_WRITE: r_state <= S_IDLE;
                S_RESP:  r_state <= S_IDLE;
                default: r_state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_imem_fetch_ctrl.sv
// Bench for imem_fetch_ctrl: random fetch/write/contention traffic against a
// transaction-level model (reference memory image, priority bit, last-fetch
// buffer) that predicts latencies and returned data from the port rules.
`timescale 1ns/1ps
module tb_imem_fetch_ctrl;
    localparam int ADDR_W  = 6;
    localparam int MEM_LAT = 2;
    localparam int DEPTH   = 1 << ADDR_W;
`ifdef IMEM_LINEBUF_EN
    localparam bit LINEBUF = 1'b1;
`else
    localparam bit LINEBUF = 1'b0;
`endif

    logic              clk = 1'b0;
    logic              rst_n;
    logic              if_req;
    logic [31:0]       if_addr;
    logic [31:0]       if_instr;
    logic              if_valid;
    logic              stall;
    logic              ld_req;
    logic [31:0]       ld_addr;
    logic [31:0]       ld_wdata;
    logic              ld_ack;
    logic [ADDR_W-1:0] mem_addr;
    logic              mem_rd;
    logic              mem_we;
    logic [31:0]       mem_wdata;
    logic [31:0]       mem_rdata;

    always #5 clk = ~clk;

    imem_fetch_ctrl #(.ADDR_W(ADDR_W), .MEM_LAT(MEM_LAT)) dut (
        .clk(clk), .rst_n(rst_n),
        .if_req(if_req), .if_addr(if_addr), .if_instr(if_instr),
        .if_valid(if_valid), .stall(stall),
        .ld_req(ld_req), .ld_addr(ld_addr), .ld_wdata(ld_wdata), .ld_ack(ld_ack),
        .mem_addr(mem_addr), .mem_rd(mem_rd), .mem_we(mem_we),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
    );

    // Memory array: data appears only in the last cycle of a MEM_LAT-long read
    logic [31:0]       mem [DEPTH];
    logic              pl_en;
    logic [ADDR_W-1:0] pl_idx;
    logic [31:0]       pl_data;
    int                rd_run = 0;

    always @(posedge clk) begin
        if (pl_en) mem[pl_idx] <= pl_data;
        else if (mem_we) mem[mem_addr] <= mem_wdata;
        rd_run <= mem_rd ? rd_run + 1 : 0;
    end
    assign mem_rdata = (mem_rd && rd_run == MEM_LAT - 1) ? mem[mem_addr] : 32'hDEAD_BEEF;

    int n_chk  = 0;
    int n_fail = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: observed 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference model state
    logic [31:0] ref_mem [DEPTH];
    bit          m_prio;
    bit          m_buf_vld;
    int          m_buf_tag;

    function automatic int idx_of(input logic [31:0] a);
        return (a >> 2) % DEPTH;
    endfunction

    function automatic int fetch_lat(input int idx);
        return (LINEBUF && m_buf_vld && m_buf_tag == idx) ? 1 : MEM_LAT + 1;
    endfunction

    task automatic model_fetch(input int idx, input bit hit);
        if (!hit) begin
            m_buf_vld = 1'b1;
            m_buf_tag = idx;
        end
        m_prio = 1'b0;
    endtask

    task automatic model_write(input int idx, input logic [31:0] data);
        ref_mem[idx] = data;
        if (m_buf_tag == idx) m_buf_vld = 1'b0;
        m_prio = 1'b1;
    endtask

    // Invariants sampled well after the falling edge
    always @(negedge clk) begin
        #2;
        chk("rd_we_exclusive", {31'b0, mem_rd & mem_we}, 32'd0);
        chk("valid_ack_exclusive", {31'b0, if_valid & ld_ack}, 32'd0);
        chk("stall", {31'b0, stall}, {31'b0, if_req & ~if_valid});
    end

    task automatic do_fetch(input logic [31:0] addr, input bit drop);
        int idx, exp_lat, n, nrd;
        bit hit;
        logic [31:0] exp_data;
        idx      = idx_of(addr);
        exp_lat  = fetch_lat(idx);
        hit      = (exp_lat == 1);
        exp_data = ref_mem[idx];
        model_fetch(idx, hit);
        if_req  = 1'b1;
        if_addr = addr;
        n = 0;
        nrd = 0;
        while (n < 20) begin
            @(negedge clk);
            n++;
            if (if_valid) break;
            if (mem_rd) begin
                nrd++;
                chk("fetch_mem_addr", {26'b0, mem_addr}, idx);
            end
            if_addr = $urandom;
            if (drop) if_req = 1'b0;
        end
        chk("fetch_latency", n, exp_lat);
        chk("fetch_data", if_instr, exp_data);
        chk("fetch_rd_cycles", nrd, hit ? 0 : MEM_LAT);
        if_req = 1'b0;
        @(negedge clk);
        chk("fetch_valid_pulse", {31'b0, if_valid}, 32'd0);
    endtask

    task automatic do_write(input logic [31:0] addr, input logic [31:0] data);
        int idx, n;
        idx = idx_of(addr);
        ld_req   = 1'b1;
        ld_addr  = addr;
        ld_wdata = data;
        n = 0;
        while (n < 20) begin
            @(negedge clk);
            n++;
            if (ld_ack) break;
        end
        chk("write_latency", n, 1);
        chk("write_we", {31'b0, mem_we}, 32'd1);
        chk("write_mem_addr", {26'b0, mem_addr}, idx);
        chk("write_wdata", mem_wdata, data);
        ld_req   = 1'b0;
        ld_addr  = $urandom;
        ld_wdata = $urandom;
        @(negedge clk);
        chk("write_ack_pulse", {31'b0, ld_ack}, 32'd0);
        chk("write_we_pulse", {31'b0, mem_we}, 32'd0);
        model_write(idx, data);
    endtask

    task automatic do_both(input logic [31:0] faddr, input logic [31:0] waddr,
                           input logic [31:0] wdata);
        int fidx, widx, t_f, t_w, lat, n, got_f, got_w;
        bit hit;
        logic [31:0] exp_f, obs_f;
        fidx = idx_of(faddr);
        widx = idx_of(waddr);
        if (m_prio) begin
            lat   = fetch_lat(fidx);
            hit   = (lat == 1);
            exp_f = ref_mem[fidx];
            model_fetch(fidx, hit);
            model_write(widx, wdata);
            t_f = lat;
            t_w = lat + 2;
        end else begin
            model_write(widx, wdata);
            lat   = fetch_lat(fidx);
            hit   = (lat == 1);
            exp_f = ref_mem[fidx];
            model_fetch(fidx, hit);
            t_w = 1;
            t_f = 2 + lat;
        end
        if_req = 1'b1; if_addr = faddr;
        ld_req = 1'b1; ld_addr = waddr; ld_wdata = wdata;
        n = 0; got_f = 0; got_w = 0; obs_f = '0;
        while (n < 30 && (got_f == 0 || got_w == 0)) begin
            @(negedge clk);
            n++;
            if (if_valid) begin
                got_f  = n;
                obs_f  = if_instr;
                if_req = 1'b0;
            end
            if (ld_ack) begin
                got_w = n;
                chk("both_wdata", mem_wdata, wdata);
                chk("both_waddr", {26'b0, mem_addr}, widx);
                ld_req = 1'b0;
            end
        end
        chk("both_fetch_cycle", got_f, t_f);
        chk("both_write_cycle", got_w, t_w);
        chk("both_fetch_data", obs_f, exp_f);
        @(negedge clk);
        chk("both_idle_after", {30'b0, if_valid, ld_ack}, 32'd0);
    endtask

    task automatic do_reset_abort();
        int idx;
        idx = (m_buf_tag + 1) % DEPTH;
        if_req  = 1'b1;
        if_addr = idx << 2;
        @(negedge clk);
        chk("abort_rd_cycle1", {31'b0, mem_rd}, 32'd1);
        @(negedge clk);
        chk("abort_rd_cycle2", {31'b0, mem_rd}, 32'd1);
        rst_n  = 1'b0;
        if_req = 1'b0;
        @(negedge clk);
        chk("abort_valid", {31'b0, if_valid}, 32'd0);
        chk("abort_rd", {31'b0, mem_rd}, 32'd0);
        chk("abort_instr", if_instr, 32'd0);
        rst_n     = 1'b1;
        m_prio    = 1'b0;
        m_buf_vld = 1'b0;
        repeat (3) begin
            @(negedge clk);
            chk("abort_no_late_valid", {31'b0, if_valid}, 32'd0);
        end
    endtask

    logic [31:0] a;
    logic [31:0] d;

    initial begin
        rst_n = 1'b0; if_req = 1'b1; if_addr = 32'h14;
        ld_req = 1'b0; ld_addr = '0; ld_wdata = '0;
        pl_en = 1'b0; pl_idx = '0; pl_data = '0;
        m_prio = 1'b0; m_buf_vld = 1'b0; m_buf_tag = 0;

        // Held in reset with a pending fetch while the memory is preloaded
        for (int i = 0; i < DEPTH; i++) begin
            @(negedge clk);
            chk("rst_strobes", {28'b0, if_valid, ld_ack, mem_rd, mem_we}, 32'd0);
            chk("rst_instr", if_instr, 32'd0);
            chk("rst_mem_addr", {26'b0, mem_addr}, 32'd0);
            chk("rst_wdata", mem_wdata, 32'd0);
            pl_en   = 1'b1;
            pl_idx  = i[ADDR_W-1:0];
            pl_data = (i == 5) ? 32'h8C09_0028 : $urandom;
            ref_mem[i] = pl_data;
        end
        @(negedge clk);
        pl_en  = 1'b0;
        if_req = 1'b0;
        rst_n  = 1'b1;

        do_fetch(32'h0000_0014, 1'b0);
        do_fetch(32'h0000_0014, 1'b0);
        do_write(32'h0000_0014, 32'h1234_5678);
        do_fetch(32'h0000_0014, 1'b0);
        do_both(32'h0000_0018, 32'h0000_0018, 32'h0000_0020);
        do_both(32'h0000_0018, 32'h0000_0018, 32'h0000_0021);
        do_write(32'h0000_0040, 32'hCAFE_0001);
        do_both(32'h0000_0040, 32'h0000_0044, 32'hCAFE_0002);
        do_fetch(32'h0000_0103, 1'b0);
        do_fetch(32'h0000_0020, 1'b1);
        do_reset_abort();
        do_fetch(32'h0000_0014, 1'b0);

        repeat (150) begin
            a = $urandom;
            d = $urandom;
            case ($urandom_range(0, 4))
                0: do_fetch(a, $urandom_range(0, 1) == 1);
                1: do_write(a, d);
                2: do_both(a, $urandom, d);
                3: do_both(a, a, d);
                default: begin
                    a[ADDR_W+1:2] = m_buf_tag[ADDR_W-1:0];
                    do_fetch(a, 1'b0);
                end
            endcase
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
